// File: rtl/updown_counter_pkg.sv
// rtl/updown_counter_pkg.sv - mode encodings shared by updown_counter and its instantiators
package updown_counter_pkg;

    typedef enum logic [1:0] {
        MODE_FREE    = 2'b00,
        MODE_SAT     = 2'b01,
        MODE_MOD     = 2'b10,
        MODE_ONESHOT = 2'b11
    } mode_t;

endpackage

// File: rtl/updown_counter_prescaler.sv
// rtl/updown_counter_prescaler.sv - Enable prescaler; tick fires on the Enable where the count matches Prescale
module updown_counter_prescaler #(
    parameter int prescale_width = 16
) (
    input  logic                      Clock,
    input  logic                      Reset,
    input  logic                      clear,
    input  logic                      Enable,
    input  logic [prescale_width-1:0] Prescale,
    output logic                      tick
);

    logic [prescale_width-1:0] count;

    assign tick = Enable && (count == Prescale);

    always_ff @(posedge Clock) begin
        if (Reset || clear) begin
            count <= '0;
        end else if (Enable) begin
            if (count == Prescale) begin
                count <= '0;
            end else begin
                count <= count + 1'b1;
            end
        end
    end

endmodule

// File: rtl/updown_counter.sv
// rtl/updown_counter.sv - up/down counter with step, free/saturate/modulo/one-shot modes; UPDOWN_COUNTER_PRESCALE_EN adds an Enable prescaler
module updown_counter
    import updown_counter_pkg::*;
#(
    parameter int               width       = 32,
    parameter int               step_width  = 8,
    parameter logic [width-1:0] reset_value = '0
`ifdef UPDOWN_COUNTER_PRESCALE_EN
    ,
    parameter int               prescale_width = 16
`endif
) (
    input  logic                  Clock,
    input  logic                  Reset,
    input  logic                  Set,
    input  logic                  Load,
    input  logic [width-1:0]      In,
    input  logic                  Enable,
    input  logic                  Up,
    input  logic [1:0]            Mode,
    input  logic [step_width-1:0] Step,
    input  logic [width-1:0]      Limit,
`ifdef UPDOWN_COUNTER_PRESCALE_EN
    input  logic [prescale_width-1:0] Prescale,
`endif
    output logic [width-1:0]      Count,
    output logic                  Terminal,
    output logic                  Done
);

    localparam logic [width-1:0] one = 1;

    mode_t            mode;
    logic [width:0]   step_ext;
    logic [width:0]   limit_ext;
    logic [width:0]   sum;
    logic [width:0]   diff;
    logic [width-1:0] mod_up;
    logic [width-1:0] mod_down;
    logic             step_zero;
    logic             step_en;

    logic [width-1:0] sat_count;
    logic             sat_term;
    logic [width-1:0] mod_count;
    logic             mod_term;
    logic [width-1:0] next_count;
    logic             next_term;
    logic             next_done;

    assign mode      = mode_t'(Mode);
    assign step_ext  = (width + 1)'(Step);
    assign limit_ext = {1'b0, Limit};
    assign sum       = {1'b0, Count} + step_ext;
    assign diff      = {1'b0, Count} - step_ext;
    assign step_zero = (Step == '0);

    // Single wrap correction, computed modulo 2^width so only the low bits are needed
    assign mod_up   = sum[width-1:0] - Limit - one;
    assign mod_down = diff[width-1:0] + Limit + one;

`ifdef UPDOWN_COUNTER_PRESCALE_EN
    logic tick;

    updown_counter_prescaler #(
        .prescale_width(prescale_width)
    ) u_prescaler (
        .Clock   (Clock),
        .Reset   (Reset),
        .clear   (Set || Load),
        .Enable  (Enable),
        .Prescale(Prescale),
        .tick    (tick)
    );

    assign step_en = tick;
`else
    assign step_en = Enable;
`endif

    always_comb begin
        sat_count = Count;
        sat_term  = 1'b0;
        if (Up) begin
            if (Count == Limit) begin
                sat_count = Count;
            end else if (sum >= limit_ext) begin
                sat_count = Limit;
                sat_term  = 1'b1;
            end else begin
                sat_count = sum[width-1:0];
            end
        end else begin
            if (Count == '0) begin
                sat_count = Count;
            end else if (diff[width] || (diff[width-1:0] == '0)) begin
                sat_count = '0;
                sat_term  = 1'b1;
            end else begin
                sat_count = diff[width-1:0];
            end
        end
    end

    always_comb begin
        mod_count = Count;
        mod_term  = 1'b0;
        if (Limit == '0) begin
            mod_count = '0;
            mod_term  = 1'b1;
        end else if (Up) begin
            if (Count > Limit) begin
                mod_count = '0;
                mod_term  = 1'b1;
            end else if (sum > limit_ext) begin
                mod_count = mod_up;
                mod_term  = 1'b1;
            end else begin
                mod_count = sum[width-1:0];
            end
        end else begin
            if (diff[width]) begin
                mod_count = mod_down;
                mod_term  = 1'b1;
            end else begin
                mod_count = diff[width-1:0];
            end
        end
    end

    always_comb begin
        next_count = Count;
        next_term  = 1'b0;
        next_done  = Done;
        if (!step_zero) begin
            case (mode)
                MODE_FREE: begin
                    if (Up) begin
                        {next_term, next_count} = sum;
                    end else begin
                        {next_term, next_count} = diff;
                    end
                end
                MODE_SAT: begin
                    next_count = sat_count;
                    next_term  = sat_term;
                end
                MODE_MOD: begin
                    next_count = mod_count;
                    next_term  = mod_term;
                end
                MODE_ONESHOT: begin
                    // A finished one-shot ignores Enable until Reset, Set or Load
                    if (!Done) begin
                        next_count = sat_count;
                        next_term  = sat_term;
                        next_done  = sat_term;
                    end
                end
                default: begin
                    next_count = Count;
                end
            endcase
        end
    end

    always_ff @(posedge Clock) begin
        if (Reset) begin
            Count    <= reset_value;
            Terminal <= 1'b0;
            Done     <= 1'b0;
        end else if (Set) begin
            Count    <= (mode == MODE_FREE) ? '1 : Limit;
            Terminal <= 1'b0;
            Done     <= 1'b0;
        end else if (Load) begin
            Count    <= In;
            Terminal <= 1'b0;
            Done     <= 1'b0;
        end else if (step_en) begin
            Count    <= next_count;
            Terminal <= next_term;
            Done     <= next_done;
        end else begin
            Terminal <= 1'b0;
        end
    end

endmodule

// File: tb/tb_updown_counter.sv
// tb/tb_updown_counter.sv - directed self-checking bench for updown_counter (width 8, reset_value 8'h5A)
module tb_updown_counter;

    logic       Clock = 1'b0;
    logic       Reset = 1'b0;
    logic       Set = 1'b0;
    logic       Load = 1'b0;
    logic [7:0] In = '0;
    logic       Enable = 1'b0;
    logic       Up = 1'b1;
    logic [1:0] Mode = 2'b00;
    logic [7:0] Step = 8'd1;
    logic [7:0] Limit = '0;
`ifdef UPDOWN_COUNTER_PRESCALE_EN
    logic [3:0] Prescale = '0;
`endif
    logic [7:0] Count;
    logic       Terminal;
    logic       Done;

    int tests = 0;
    int fails = 0;

    updown_counter #(
        .width      (8),
        .step_width (8),
        .reset_value(8'h5A)
`ifdef UPDOWN_COUNTER_PRESCALE_EN
        ,
        .prescale_width(4)
`endif
    ) dut (
        .Clock   (Clock),
        .Reset   (Reset),
        .Set     (Set),
        .Load    (Load),
        .In      (In),
        .Enable  (Enable),
        .Up      (Up),
        .Mode    (Mode),
        .Step    (Step),
        .Limit   (Limit),
`ifdef UPDOWN_COUNTER_PRESCALE_EN
        .Prescale(Prescale),
`endif
        .Count   (Count),
        .Terminal(Terminal),
        .Done    (Done)
    );

    always #5 Clock = ~Clock;

    task automatic tick();
        @(posedge Clock);
        #1;
    endtask

    task automatic chk(input string tag, input logic [31:0] observed, input logic [31:0] expected);
        tests++;
        assert (observed === expected)
        else begin
            fails++;
            $error("FAIL %s: observed %0h expected %0h", tag, observed, expected);
        end
    endtask

    task automatic chk_ct(input string tag, input logic [7:0] c, input logic t);
        chk({tag, ".count"}, 32'(Count), 32'(c));
        chk({tag, ".term"}, 32'(Terminal), 32'(t));
    endtask

    initial begin
        Reset = 1'b1;
        tick();
        chk_ct("reset", 8'h5A, 1'b0);
        chk("reset.done", 32'(Done), 32'd0);
        Reset = 1'b0;

        // Free-wrap up across the carry, then down across the borrow, then Step 0
        Mode = 2'b00; Up = 1'b1; Step = 8'd1;
        Load = 1'b1; In = 8'hFE; tick(); Load = 1'b0;
        chk_ct("free.load", 8'hFE, 1'b0);
        Enable = 1'b1;
        tick(); chk_ct("free.up1", 8'hFF, 1'b0);
        tick(); chk_ct("free.up2", 8'h00, 1'b1);
        tick(); chk_ct("free.up3", 8'h01, 1'b0);
        Up = 1'b0;
        tick(); chk_ct("free.dn1", 8'h00, 1'b0);
        tick(); chk_ct("free.dn2", 8'hFF, 1'b1);
        Step = 8'd0;
        tick(); chk_ct("free.step0", 8'hFF, 1'b0);
        Enable = 1'b0;

        // Mode change without Enable keeps Count; next Enable clamps above-Limit to Limit
        Mode = 2'b01; Limit = 8'd10; Up = 1'b1; Step = 8'd4;
        tick(); chk_ct("modechg.hold", 8'hFF, 1'b0);
        Enable = 1'b1;
        tick(); chk_ct("sat.above", 8'd10, 1'b1);
        Enable = 1'b0;

        // Saturate up and down
        Load = 1'b1; In = 8'd0; tick(); Load = 1'b0;
        Enable = 1'b1;
        tick(); chk_ct("sat.up1", 8'd4, 1'b0);
        tick(); chk_ct("sat.up2", 8'd8, 1'b0);
        tick(); chk_ct("sat.up3", 8'd10, 1'b1);
        tick(); chk_ct("sat.up4", 8'd10, 1'b0);
        Up = 1'b0;
        tick(); chk_ct("sat.dn1", 8'd6, 1'b0);
        tick(); chk_ct("sat.dn2", 8'd2, 1'b0);
        tick(); chk_ct("sat.dn3", 8'd0, 1'b1);
        tick(); chk_ct("sat.dn4", 8'd0, 1'b0);
        Enable = 1'b0;

        // Modulo 10
        Mode = 2'b10; Limit = 8'd9; Step = 8'd3; Up = 1'b0;
        Load = 1'b1; In = 8'd1; tick(); Load = 1'b0;
        Enable = 1'b1;
        tick(); chk_ct("mod.dn1", 8'd8, 1'b1);
        tick(); chk_ct("mod.dn2", 8'd5, 1'b0);
        Up = 1'b1;
        tick(); chk_ct("mod.up1", 8'd8, 1'b0);
        tick(); chk_ct("mod.up2", 8'd1, 1'b1);
        Enable = 1'b0;
        Load = 1'b1; In = 8'd200; tick(); Load = 1'b0;
        Enable = 1'b1;
        tick(); chk_ct("mod.above", 8'd0, 1'b1);
        Limit = 8'd0; Step = 8'd1;
        tick(); chk_ct("mod.lim0a", 8'd0, 1'b1);
        tick(); chk_ct("mod.lim0b", 8'd0, 1'b1);
        Mode = 2'b01;
        tick(); chk_ct("sat.lim0", 8'd0, 1'b0);
        Enable = 1'b0;

        // One-shot
        Mode = 2'b11; Limit = 8'd3; Step = 8'd1; Up = 1'b1;
        Load = 1'b1; In = 8'd0; tick(); Load = 1'b0;
        Enable = 1'b1;
        tick(); chk_ct("os.1", 8'd1, 1'b0); chk("os.1.done", 32'(Done), 32'd0);
        tick(); chk_ct("os.2", 8'd2, 1'b0);
        tick(); chk_ct("os.3", 8'd3, 1'b1); chk("os.3.done", 32'(Done), 32'd1);
        tick(); chk_ct("os.4", 8'd3, 1'b0); chk("os.4.done", 32'(Done), 32'd1);
        tick(); chk_ct("os.5", 8'd3, 1'b0);
        Enable = 1'b0;
        Load = 1'b1; In = 8'd0; tick(); Load = 1'b0;
        chk("os.load.done", 32'(Done), 32'd0);
        Enable = 1'b1;
        tick(); chk_ct("os.resume", 8'd1, 1'b0);

        // Priority
        Reset = 1'b1; Set = 1'b1; Load = 1'b1; In = 8'h33;
        tick(); chk_ct("prio.reset", 8'h5A, 1'b0);
        Reset = 1'b0; Enable = 1'b0;
        Mode = 2'b10; Limit = 8'd7; In = 8'd3;
        tick(); chk_ct("prio.set", 8'd7, 1'b0);
        Set = 1'b0; Mode = 2'b00; In = 8'h20; Enable = 1'b1;
        tick(); chk_ct("prio.load_en", 8'h20, 1'b0);
        Load = 1'b0; Enable = 1'b0; Set = 1'b1;
        tick(); chk_ct("set.free", 8'hFF, 1'b0);
        Set = 1'b0;

`ifdef UPDOWN_COUNTER_PRESCALE_EN
        // Prescale 2: every third Enable steps; Load restarts the period
        Mode = 2'b00; Up = 1'b1; Step = 8'd1; Prescale = 4'd2;
        Load = 1'b1; In = 8'd0; tick(); Load = 1'b0;
        Enable = 1'b1;
        tick(); chk_ct("ps.e1", 8'd0, 1'b0);
        tick(); chk_ct("ps.e2", 8'd0, 1'b0);
        tick(); chk_ct("ps.e3", 8'd1, 1'b0);
        tick(); tick(); chk_ct("ps.e5", 8'd1, 1'b0);
        tick(); chk_ct("ps.e6", 8'd2, 1'b0);
        tick(); tick(); tick(); chk_ct("ps.e9", 8'd3, 1'b0);
        tick(); tick();
        Enable = 1'b0; Load = 1'b1; In = 8'd0; tick(); Load = 1'b0;
        Enable = 1'b1;
        tick(); tick(); chk_ct("ps.rst2", 8'd0, 1'b0);
        tick(); chk_ct("ps.rst3", 8'd1, 1'b0);
        Enable = 1'b0;
`endif

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
